// File: rtl/sparse_encoder.sv
// Dense-to-sparse encoder: captures an N-lane vector, emits its occupancy mask and
// streams the non-zero lanes one beat each in ascending lane order (first beat one cycle after capture).
module sparse_encoder #(
  parameter  int N  = 8,
  parameter  int DW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_mask,
  output logic [IW:0]     out_nnz,
  output logic [IW-1:0]   out_idx,
  output logic [DW-1:0]   out_value,
  output logic            out_last
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N*DW-1:0]   r_data;
  logic [N-1:0]      r_mask;
  logic [N-1:0]      r_rem;
  logic [IW:0]       r_nnz;

  logic [N-1:0]      w_in_mask;
  logic [IW:0]       w_in_cnt;
  logic [IW:0]       w_rem_cnt;
  logic [IW-1:0]     w_idx;
  logic [DW-1:0]     w_lane;
  logic              w_last;
  logic              w_cap;
  logic              w_adv;
  logic              w_drain;

  function automatic logic [IW:0] popcnt(input logic [N-1:0] v);
    logic [IW:0] c;
    c = '0;
    for (int k = 0; k < N; k++) c = c + {{IW{1'b0}}, v[k]};
    return c;
  endfunction

  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < N; k++) w_in_mask[k] = |in_data[k*DW +: DW];
    w_in_cnt  = popcnt(w_in_mask);
    w_rem_cnt = popcnt(r_rem);
    w_last    = (w_rem_cnt <= (IW+1)'(1));
  end

  // Scan downward so the lowest set bit wins; an empty rem yields lane 0.
  always_comb begin
    w_idx  = '0;
    w_lane = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (r_rem[k]) w_idx = IW'(k);
    end
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == w_idx) w_lane = r_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_idx     = '0;
    out_value   = '0;
    out_last    = 1'b0;
    w_cap       = 1'b0;
    w_adv       = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_idx   = w_idx;
        out_value = w_lane;
        out_last  = w_last;
        if (out_ready) begin
          if (w_last) begin
            // Last beat accepted: a waiting vector is taken in the same cycle.
            in_ready = 1'b1;
            if (in_valid) begin
              w_cap = 1'b1;
            end else begin
              w_drain     = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_rem  <= '0;
      r_nnz  <= '0;
    end else if (w_cap) begin
      r_data <= in_data;
      r_mask <= w_in_mask;
      r_rem  <= w_in_mask;
      r_nnz  <= w_in_cnt;
    end else if (w_adv) begin
      r_rem[w_idx] <= 1'b0;
    end else if (w_drain) begin
      r_rem <= '0;
    end
  end

  assign out_mask = r_mask;
  assign out_nnz  = r_nnz;

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed, table-driven bench for sparse_encoder: per-vector beat tables plus
// hand sequences for back-to-back capture, stalls and mid-vector reset.
module tb_sparse_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_mask;
  logic [3:0]  out_nnz;
  logic [2:0]  out_idx;
  logic [7:0]  out_value;
  logic        out_last;

  always #5 clk = ~clk;

  sparse_encoder #(.N(8), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_nnz   (out_nnz),
    .out_idx   (out_idx),
    .out_value (out_value),
    .out_last  (out_last)
  );

  typedef struct {
    logic [63:0]     data;
    logic [7:0]      mask;
    logic [3:0]      nnz;
    int              nb;
    logic [7:0][2:0] idx;
    logic [7:0][7:0] val;
  } vec_t;

  vec_t tv [5];
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Checks every beat of an already-captured vector; in_valid is held at hold_valid.
  task automatic emit_check(input int e, input bit stall, input bit hold_valid);
    int b;
    int cyc;
    bit last_exp;
    b   = 0;
    cyc = 0;
    while (b < tv[e].nb && cyc < 64) begin
      @(negedge clk);
      in_valid  = hold_valid;
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      #1;
      last_exp = (b == tv[e].nb - 1);
      chk("beat_valid", 64'(out_valid), 64'(1'b1));
      chk("beat_idx",   64'(out_idx),   64'(tv[e].idx[b]));
      chk("beat_value", 64'(out_value), 64'(tv[e].val[b]));
      chk("beat_last",  64'(out_last),  64'(last_exp));
      chk("beat_mask",  64'(out_mask),  64'(tv[e].mask));
      chk("beat_nnz",   64'(out_nnz),   64'(tv[e].nnz));
      chk("beat_in_ready", 64'(in_ready), 64'(out_ready & last_exp));
      if (out_ready) b++;
      cyc++;
    end
    if (b < tv[e].nb) chk("beat_timeout", 64'(b), 64'(tv[e].nb));
  endtask

  // Presents vector e while the encoder is idle; capture happens on the next edge.
  task automatic send(input int e);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = tv[e].data;
    out_ready = 1'b1;
    #1;
    chk("cap_in_ready", 64'(in_ready), 64'(1'b1));
    chk("cap_no_valid", 64'(out_valid), 64'(1'b0));
  endtask

  task automatic idle_check();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("idle_valid", 64'(out_valid), 64'(1'b0));
    chk("idle_ready", 64'(in_ready),  64'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{64'h0605040302000001, 8'b11111001, 4'd6, 6,
              {3'd0,3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd0},
              {8'h00,8'h00,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01}};
    tv[1] = '{64'h007F800044332211, 8'b01101111, 4'd6, 6,
              {3'd0,3'd0,3'd6,3'd5,3'd3,3'd2,3'd1,3'd0},
              {8'h00,8'h00,8'h7F,8'h80,8'h44,8'h33,8'h22,8'h11}};
    tv[2] = '{64'h0, 8'b00000000, 4'd0, 1, '0, '0};
    tv[3] = '{64'h0807060504030201, 8'b11111111, 4'd8, 8,
              {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0},
              {8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01}};
    tv[4] = '{64'h000000FF00000000, 8'b00010000, 4'd1, 1,
              {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4},
              {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF}};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_mask",  64'(out_mask),  64'(8'h00));
    chk("rst_nnz",   64'(out_nnz),   64'(4'd0));
    chk("rst_idx",   64'(out_idx),   64'(3'd0));
    chk("rst_value", 64'(out_value), 64'(8'h00));
    chk("rst_last",  64'(out_last),  64'(1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_check();

    for (int e = 0; e < 5; e++) begin
      send(e);
      emit_check(e, 1'b0, 1'b0);
      idle_check();
    end

    // Back-to-back: second vector waits on in_data while the first drains.
    send(0);
    @(posedge clk);
    #1 in_data = tv[1].data;
    emit_check(0, 1'b0, 1'b1);
    emit_check(1, 1'b0, 1'b0);
    idle_check();

    // Downstream stalls with pattern 1,0,0,1.
    send(3);
    emit_check(3, 1'b1, 1'b0);
    idle_check();

    // Reset during the third beat of a full vector.
    send(3);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre_rst_idx", 64'(out_idx), 64'(b));
    end
    @(negedge clk);
    #1;
    chk("third_beat_idx", 64'(out_idx), 64'(3'd2));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(1'b0));
    chk("mid_rst_mask",  64'(out_mask),  64'(8'h00));
    chk("mid_rst_nnz",   64'(out_nnz),   64'(4'd0));
    chk("mid_rst_idx",   64'(out_idx),   64'(3'd0));
    chk("mid_rst_value", 64'(out_value), 64'(8'h00));
    chk("mid_rst_last",  64'(out_last),  64'(1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready),  64'(1'b1));
    chk("post_rst_valid", 64'(out_valid), 64'(1'b0));
    idle_check();
    send(4);
    emit_check(4, 1'b0, 1'b0);
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_encoder.md
# sparse_encoder

Dense-to-sparse compressor for the sparse systolic array datapath. It accepts one dense vector of N signed 8-bit elements per handshake. It produces the N-bit occupancy mask consumed by the pair-lookup list (comp1/comp2 format) and streams out the non-zero elements one per beat, in ascending lane order, each tagged with its lane index. It sits between the operand buffers and the sparse PE feeders: it writes the masks that the list reads.

## Interface
- N, 8, lanes per vector (index width log2(N)=3, mask width N)
- DW, 8, element width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  dense vector present
- in_ready  output  1  encoder can accept a vector this cycle
- in_data  input  N*DW  dense vector; lane k = in_data[k*DW +: DW]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_mask  output  N  occupancy mask of current vector; bit k=1 iff lane k non-zero
- out_nnz  output  log2(N)+1  popcount of out_mask (0..N)
- out_idx  output  log2(N)  lane index of current beat
- out_value  output  DW  element value of current beat
- out_last  output  1  final beat of current vector

## Operation
- States: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: register in_data, compute mask (lane != 0), register it into out_mask and a working copy rem, register popcount into out_nnz, go to EMIT.
- EMIT: out_valid=1. out_idx = lowest set bit of rem; out_value = registered lane out_idx; out_last = (popcount(rem) <= 1).
- On out_valid&out_ready in EMIT, not last: clear bit out_idx in rem, stay in EMIT.
- On out_valid&out_ready with out_last: if in_valid, capture the new vector (back-to-back) and stay in EMIT; else go to IDLE.
- in_ready = (state==IDLE) | (state==EMIT & out_ready & out_last). This is a combinational path from out_ready.
- All-zero vector: mask=0, nnz=0. Exactly one beat is emitted with out_idx=0, out_value=0, out_last=1.
- out_mask and out_nnz stay constant for every beat of a vector and change only on a capture.
- Stall (out_ready=0): all out_* outputs hold stable while out_valid=1. rem is not modified.
- Zero test is bitwise (all DW bits 0). Any non-zero pattern, including 8'h80, counts as non-zero.
- in_data is ignored whenever in_ready=0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1 after release, out_valid=0, out_mask=0, out_nnz=0, out_idx=0, out_value=0, out_last=0, rem=0, data register=0.
- Reset mid-vector aborts the vector. No partial beats are emitted after release.
- Latency: a vector captured at edge t gives its first beat valid in the cycle after t.
- Throughput: max(nnz,1) cycles per vector with out_ready held high. There are no bubbles between vectors when in_valid is held.
- Single non-zero lane: first beat has out_last=1.
- Full vector (mask all ones): N beats, idx 0..N-1, out_nnz=N (width log2(N)+1 required).

## Test plan
- Lanes 0,3,4,5,6,7 = 1,2,3,4,5,6, others 0; out_ready=1 -> out_mask=8'b11111001, out_nnz=6, beats (idx,value) = (0,1),(3,2),(4,3),(5,4),(6,5),(7,6), last only on idx 7.
- Lanes 0,1,2,3,5,6 non-zero, lane 5 = 8'h80 -> out_mask=8'b01101111, out_nnz=6, idx sequence 0,1,2,3,5,6, beat idx 5 carries 8'h80.
- All-zero vector -> one beat: mask=0, nnz=0, idx=0, value=0, last=1; in_ready high in that cycle.
- Two vectors presented back-to-back with in_valid held and out_ready=1 -> second vector's first beat immediately follows first vector's last beat; in_ready pulses only on capture cycles.
- out_ready toggled 1,0,0,1,… during a vector -> no beat dropped or duplicated; outputs stable during stalls; in_ready=0 throughout EMIT except the accepted last beat.
- rst asserted during the third beat of an 8-nnz vector -> outputs go to reset values immediately; after release in_ready=1, out_valid=0, and the next vector encodes correctly.
